xor_popcount_acc: RTL
=====================

// Module: xor_popcount_acc
// PURPOSE
//   Downstream consumer of the 32-bit XOR unit for the TinyML binary-NN path.
//   Takes a stream of XOR results (A^B words), counts set bits per word and
//   accumulates them into a Hamming-distance sum over LEN words.
//   Handshakes with the operand sequencer via X_VALID/X_READY.
//   Signals completion with a one-cycle DONE pulse to the EX/WB stage.
// PARAMETERS
//   WIDTH  32  data word width; popcount width is $clog2(WIDTH+1)
//   CNT_W  12  accumulator width (ACC range 0..2^CNT_W-1)
//   LEN_W  8   word-count width (LEN range 0..2^LEN_W-1)
// PORTS
//   CLK      in   1      clock, rising edge
//   RST      in   1      reset, asynchronous, active-high
//   START    in   1      begin a new accumulation; sampled only in IDLE
//   LEN      in   LEN_W  number of words to accumulate; sampled with START
//   X_IN     in   WIDTH  XOR result word (output O of the XOR unit)
//   X_VALID  in   1      X_IN valid this cycle
//   X_READY  out  1      block accepts X_IN this cycle
//   ACC      out  CNT_W  running / final Hamming-distance sum
//   BUSY     out  1      high in RUN and DONE states
//   DONE     out  1      one-cycle pulse: ACC holds the final sum
// BEHAVIOUR
//   - Reset (async, RST=1): state=IDLE, ACC=0, remaining=0, X_READY=0,
//     BUSY=0, DONE=0. Reset mid-run aborts: no DONE, partial ACC discarded.
//   - States: IDLE, RUN, DONE (registered, one-hot or binary, 3 states).
//   - IDLE: X_READY=0. START=1 & LEN!=0 -> ACC<=0, remaining<=LEN, go RUN.
//     START=1 & LEN==0 -> ACC<=0, go DONE (no words consumed).
//   - RUN: X_READY=1 (registered from state, no combinational path from
//     X_VALID). Accept = X_VALID & X_READY.
//     On accept: ACC <= ACC + popcount(X_IN), remaining <= remaining-1.
//     Accept with remaining==1 -> go DONE. No accept -> hold all state.
//   - DONE: DONE=1 for exactly one cycle, X_READY=0, then go IDLE.
//   - Latency: DONE asserted the cycle after the last word is accepted; ACC
//     already final in that cycle. ACC holds its value in IDLE until the
//     next accepted START.
//   - START in RUN or DONE ignored (no restart, no queueing).
//   - Arithmetic: popcount zero-extended to CNT_W; sum wraps mod 2^CNT_W.
//   - Throughput: one word per cycle while X_VALID held high.
// CONFIGURATION
//   - XPOP_SAT_EN defined: accumulator saturates at 2^CNT_W-1; once saturated
//     it stays there until next START. Word count/DONE timing unchanged.
//   - XPOP_SAT_EN undefined: accumulator wraps modulo 2^CNT_W (default).
// TESTING
//   1. LEN=1, X_IN=32'hFFFF_FFFF, X_VALID=1 -> one accept, DONE pulse next
//      cycle, ACC=32, BUSY low the cycle after DONE.
//   2. LEN=3, words 32'h0000_000F, 32'h8000_0001, 32'h0 with X_VALID low
//      for 2 cycles between words -> ACC=6, exactly 3 accepts, DONE 1 cycle
//      after 3rd accept.
//   3. START with LEN=0 -> DONE next cycle, ACC=0, X_READY never high.
//   4. CNT_W=12, LEN=130, all words 32'hFFFF_FFFF -> without XPOP_SAT_EN
//      ACC=64 (4160 mod 4096); with XPOP_SAT_EN ACC=4095.
//   5. LEN=4, RST pulsed after 2 accepts -> ACC=0, IDLE, X_READY=0, no DONE;
//      separately, START pulsed during RUN -> ignored, sum and count intact.

Source files
------------

// File: rtl/xor_popcount_acc.sv
// xor_popcount_acc: Hamming-distance accumulator for the binary-NN path.
// Consumes a stream of XOR result words over a valid/ready handshake.
// It adds the popcount of each accepted word into ACC for LEN words, then
// pulses DONE for one cycle.
// Optional feature macro: XPOP_SAT_EN. When it is defined, ACC saturates at
// 2^CNT_W-1 instead of wrapping.
module xor_popcount_acc #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 12,
   parameter int LEN_W = 8
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             START,
   input  logic [LEN_W-1:0] LEN,
   input  logic [WIDTH-1:0] X_IN,
   input  logic             X_VALID,
   output logic             X_READY,
   output logic [CNT_W-1:0] ACC,
   output logic             BUSY,
   output logic             DONE
);

   localparam int PC_W = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t           state;
   logic [LEN_W-1:0] remaining;
   logic [PC_W-1:0]  pc_p0;
   logic             accept;

   // Number of set bits in one word.
   function automatic logic [PC_W-1:0] popcount(input logic [WIDTH-1:0] w);
      logic [PC_W-1:0] c;
      c = '0;
      for (int i = 0; i < WIDTH; i++) begin
         c = c + PC_W'(w[i]);
      end
      return c;
   endfunction

   // Accumulator update: zero-extended add, wrapping or saturating.
   function automatic logic [CNT_W-1:0] acc_add(input logic [CNT_W-1:0] a,
                                                input logic [PC_W-1:0]  p);
      logic [CNT_W:0] s;
      s = {1'b0, a} + (CNT_W + 1)'(p);
`ifdef XPOP_SAT_EN
      if (s[CNT_W]) begin
         return '1;
      end
      return s[CNT_W-1:0];
`else
      return s[CNT_W-1:0];
`endif
   endfunction

   // Stage 0: combinational popcount of the offered word
   assign pc_p0  = popcount(X_IN);
   assign accept = X_VALID & X_READY;

   // Control FSM with registered handshake/status outputs and the accumulator
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state     <= ST_IDLE;
         ACC       <= '0;
         remaining <= '0;
         X_READY   <= 1'b0;
         BUSY      <= 1'b0;
         DONE      <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               DONE <= 1'b0;
               if (START) begin
                  ACC  <= '0;
                  BUSY <= 1'b1;
                  if (LEN != '0) begin
                     remaining <= LEN;
                     X_READY   <= 1'b1;
                     state     <= ST_RUN;
                  end else begin
                     // Empty job: finish without consuming any word.
                     DONE  <= 1'b1;
                     state <= ST_DONE;
                  end
               end
            end
            ST_RUN: begin
               if (accept) begin
                  ACC       <= acc_add(ACC, pc_p0);
                  remaining <= remaining - LEN_W'(1);
                  if (remaining == LEN_W'(1)) begin
                     X_READY <= 1'b0;
                     DONE    <= 1'b1;
                     state   <= ST_DONE;
                  end
               end
            end
            ST_DONE: begin
               DONE    <= 1'b0;
               BUSY    <= 1'b0;
               X_READY <= 1'b0;
               state   <= ST_IDLE;
            end
            default: begin
               DONE    <= 1'b0;
               BUSY    <= 1'b0;
               X_READY <= 1'b0;
               state   <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
